// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder: ALUOp classes, ALUControl codes
// and R-type Funct codes.
package alu_ctrl_pkg;

    localparam logic [3:0] ALUOP_RTYPE  = 4'b0000;
    localparam logic [3:0] ALUOP_ADDI   = 4'b0001;
    localparam logic [3:0] ALUOP_SLTI   = 4'b0010;
    localparam logic [3:0] ALUOP_ANDI   = 4'b0011;
    localparam logic [3:0] ALUOP_ORI    = 4'b0100;
    localparam logic [3:0] ALUOP_XORI   = 4'b0101;
    localparam logic [3:0] ALUOP_LUI    = 4'b0110;
    localparam logic [3:0] ALUOP_BRANCH = 4'b0111;
    localparam logic [3:0] ALUOP_SW     = 4'b1000;
    localparam logic [3:0] ALUOP_LW     = 4'b1001;
    localparam logic [3:0] ALUOP_SLTIU  = 4'b1010;

    localparam logic [3:0] ALUC_AND  = 4'b0000;
    localparam logic [3:0] ALUC_OR   = 4'b0001;
    localparam logic [3:0] ALUC_ADD  = 4'b0010;
    localparam logic [3:0] ALUC_SLT  = 4'b0011;
    localparam logic [3:0] ALUC_XOR  = 4'b0100;
    localparam logic [3:0] ALUC_NOR  = 4'b0101;
    localparam logic [3:0] ALUC_SUB  = 4'b0110;
    localparam logic [3:0] ALUC_LUI  = 4'b0111;
    localparam logic [3:0] ALUC_SLTU = 4'b1000;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU = 6'b101011;

endpackage

// File: rtl/alu_ctrl_issue_pipe_if.sv
// Issue-side bundle bus: upstream decode handshake, downstream execute handshake,
// flush and the illegal-op counter.
interface alu_ctrl_issue_pipe_if #(
    parameter int LANES  = 2,
    parameter int OP_W   = 4,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES-1:0]        lane_en_i;
    logic [LANES*OP_W-1:0]   aluop_i;
    logic [LANES*6-1:0]      funct_i;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*CTRL_W-1:0] alu_ctrl_o;
    logic [LANES-1:0]        lane_valid_o;
    logic [LANES-1:0]        illegal_o;
    logic [CNT_W-1:0]        illegal_cnt_o;

    modport master (
        output in_valid, lane_en_i, aluop_i, funct_i, flush, out_ready,
        input  in_ready, out_valid, alu_ctrl_o, lane_valid_o, illegal_o, illegal_cnt_o
    );

    modport slave (
        input  in_valid, lane_en_i, aluop_i, funct_i, flush, out_ready,
        output in_ready, out_valid, alu_ctrl_o, lane_valid_o, illegal_o, illegal_cnt_o
    );
endinterface

// File: rtl/alu_ctrl_lane_dec.sv
// Single-lane combinational ALU control decoder: {ALUOp, Funct} -> {ALUControl, illegal}.
module alu_ctrl_lane_dec
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W   = 4,
    parameter int CTRL_W = 4
) (
    input  logic [OP_W-1:0]   aluop,
    input  logic [5:0]        funct,
    output logic [CTRL_W-1:0] ctrl,
    output logic              illegal
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        ctrl    = '0;
        illegal = 1'b0;
        case (aluop)
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD, FUNCT_ADDU: ctrl = ALUC_ADD;
                    FUNCT_SUB, FUNCT_SUBU: ctrl = ALUC_SUB;
                    FUNCT_AND:             ctrl = ALUC_AND;
                    FUNCT_OR:              ctrl = ALUC_OR;
                    FUNCT_XOR:             ctrl = ALUC_XOR;
                    FUNCT_NOR:             ctrl = ALUC_NOR;
                    FUNCT_SLT:             ctrl = ALUC_SLT;
                    FUNCT_SLTU:            ctrl = ALUC_SLTU;
                    default:               illegal = 1'b1;
                endcase
            end
            ALUOP_ADDI:          ctrl = ALUC_ADD;
            ALUOP_SLTI:          ctrl = ALUC_SLT;
            ALUOP_ANDI:          ctrl = ALUC_AND;
            ALUOP_ORI:           ctrl = ALUC_OR;
            ALUOP_XORI:          ctrl = ALUC_XOR;
            ALUOP_LUI:           ctrl = ALUC_LUI;
            ALUOP_BRANCH:        ctrl = ALUC_SUB;
            ALUOP_SW, ALUOP_LW:  ctrl = ALUC_ADD;
            ALUOP_SLTIU:         ctrl = ALUC_SLTU;
            default:             illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_issue_pipe.sv
// Multi-lane registered ALU control decoder with a 2-entry skid buffer, flush
// and a saturating illegal-op counter.
module alu_ctrl_issue_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int OP_W   = 4,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 8
) (
    input logic               clk,
    input logic               rst,
    alu_ctrl_issue_pipe_if.slave bus
);

    logic [LANES*CTRL_W-1:0] dec_ctrl;
    logic [LANES-1:0]        dec_illegal;
    logic [LANES-1:0]        new_illegal;
    logic [2:0]              new_pop;
    logic [CNT_W:0]          cnt_sum;
    logic [CNT_W-1:0]        cnt_next;

    // Entry 0 is the head that drives the outputs; entry 1 is the skid.
    logic                    v0, v1, rdy_q;
    logic [LANES*CTRL_W-1:0] e0_ctrl, e1_ctrl;
    logic [LANES-1:0]        e0_en, e1_en, e0_ill, e1_ill;
    logic [CNT_W-1:0]        cnt;

    logic accept, consume;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        alu_ctrl_lane_dec #(.OP_W(OP_W), .CTRL_W(CTRL_W)) u_dec (
            .aluop   (bus.aluop_i[k*OP_W +: OP_W]),
            .funct   (bus.funct_i[k*6 +: 6]),
            .ctrl    (dec_ctrl[k*CTRL_W +: CTRL_W]),
            .illegal (dec_illegal[k])
        );
    end

    assign new_illegal = dec_illegal & bus.lane_en_i;
    assign accept      = bus.in_valid & rdy_q & ~bus.flush;
    assign consume     = v0 & bus.out_ready;

    always_comb begin
        new_pop = '0;
        for (int k = 0; k < LANES; k++) begin
            new_pop = new_pop + 3'(new_illegal[k]);
        end
    end

    // One spare bit catches the carry so the counter clamps instead of wrapping.
    assign cnt_sum  = {1'b0, cnt} + {{(CNT_W-2){1'b0}}, new_pop};
    assign cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0      <= 1'b0;
            v1      <= 1'b0;
            rdy_q   <= 1'b1;
            e0_ctrl <= '0;
            e0_en   <= '0;
            e0_ill  <= '0;
            e1_ctrl <= '0;
            e1_en   <= '0;
            e1_ill  <= '0;
        end else if (bus.flush) begin
            v0    <= 1'b0;
            v1    <= 1'b0;
            rdy_q <= 1'b1;
        end else begin
            case ({accept, consume})
                2'b10: begin
                    if (!v0) begin
                        v0      <= 1'b1;
                        e0_ctrl <= dec_ctrl;
                        e0_en   <= bus.lane_en_i;
                        e0_ill  <= new_illegal;
                    end else begin
                        v1      <= 1'b1;
                        rdy_q   <= 1'b0;
                        e1_ctrl <= dec_ctrl;
                        e1_en   <= bus.lane_en_i;
                        e1_ill  <= new_illegal;
                    end
                end
                2'b01: begin
                    if (v1) begin
                        v1      <= 1'b0;
                        rdy_q   <= 1'b1;
                        e0_ctrl <= e1_ctrl;
                        e0_en   <= e1_en;
                        e0_ill  <= e1_ill;
                    end else begin
                        v0 <= 1'b0;
                    end
                end
                2'b11: begin
                    // Accept is only possible at count 1 here, since the skid is empty.
                    e0_ctrl <= dec_ctrl;
                    e0_en   <= bus.lane_en_i;
                    e0_ill  <= new_illegal;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= cnt_next;
        end
    end

    assign bus.in_ready      = rdy_q;
    assign bus.out_valid     = v0;
    assign bus.alu_ctrl_o    = e0_ctrl;
    assign bus.lane_valid_o  = e0_en;
    assign bus.illegal_o     = e0_ill;
    assign bus.illegal_cnt_o = cnt;

endmodule

// File: tb/tb_alu_ctrl_issue_pipe.sv
// Directed bench for alu_ctrl_issue_pipe: decode table, illegal masking, backpressure,
// flush, counter saturation (second instance with a 4-bit counter) and async reset.
module tb_alu_ctrl_issue_pipe;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    alu_ctrl_issue_pipe_if #(.LANES(2), .OP_W(4), .CTRL_W(4), .CNT_W(8)) mif ();
    alu_ctrl_issue_pipe_if #(.LANES(2), .OP_W(4), .CTRL_W(4), .CNT_W(4)) sif ();

    assign sif.in_valid  = mif.in_valid;
    assign sif.lane_en_i = mif.lane_en_i;
    assign sif.aluop_i   = mif.aluop_i;
    assign sif.funct_i   = mif.funct_i;
    assign sif.flush     = mif.flush;
    assign sif.out_ready = mif.out_ready;

    alu_ctrl_issue_pipe #(.LANES(2), .OP_W(4), .CTRL_W(4), .CNT_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (mif.slave)
    );

    alu_ctrl_issue_pipe #(.LANES(2), .OP_W(4), .CTRL_W(4), .CNT_W(4)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    task automatic drive(input logic v, input logic [1:0] en,
                         input logic [3:0] op1, input logic [5:0] f1,
                         input logic [3:0] op0, input logic [5:0] f0);
        mif.in_valid  = v;
        mif.lane_en_i = en;
        mif.aluop_i   = {op1, op0};
        mif.funct_i   = {f1, f0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {in_ready, out_valid, lane_valid_o, illegal_o, ctrl lane1, ctrl lane0}
    function automatic logic [13:0] head();
        return {mif.in_ready, mif.out_valid, mif.lane_valid_o, mif.illegal_o, mif.alu_ctrl_o};
    endfunction

    function automatic logic [13:0] mk(input logic rdy, input logic ov, input logic [1:0] lv,
                                       input logic [1:0] il, input logic [3:0] c1, input logic [3:0] c0);
        return {rdy, ov, lv, il, c1, c0};
    endfunction

    function automatic logic [3:0] sat15(input int v);
        return (v > 15) ? 4'd15 : 4'(v);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 2'b00, 4'h0, 6'h0, 4'h0, 6'h0);
        mif.flush     = 1'b0;
        mif.out_ready = 1'b0;
        #12;
        total++;
        if (head() !== 14'h2000) begin
            bad++;
            $display("FAIL reset_head got=%h exp=%h", head(), 14'h2000);
        end
        total++;
        if (mif.illegal_cnt_o !== 8'd0 || sif.illegal_cnt_o !== 4'd0) begin
            bad++;
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0", mif.illegal_cnt_o, sif.illegal_cnt_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_decode();
        logic [3:0]  op1 [10] = '{4'b0110, 4'b1010, 4'b0000, 4'b0011, 4'b0101,
                                  4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic [5:0]  f1  [10] = '{6'b0, 6'b0, 6'b101011, 6'b0, 6'b0,
                                  6'b0, 6'b100101, 6'b100110, 6'b100100, 6'b100011};
        logic [3:0]  op0 [10] = '{4'b0000, 4'b0001, 4'b0000, 4'b0111, 4'b0100,
                                  4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        logic [5:0]  f0  [10] = '{6'b100010, 6'b0, 6'b100111, 6'b0, 6'b0,
                                  6'b0, 6'b0, 6'b100000, 6'b101010, 6'b100001};
        logic [3:0]  c1  [10] = '{4'b0111, 4'b1000, 4'b1000, 4'b0000, 4'b0100,
                                  4'b0010, 4'b0001, 4'b0100, 4'b0000, 4'b0110};
        logic [3:0]  c0  [10] = '{4'b0110, 4'b0010, 4'b0101, 4'b0110, 4'b0001,
                                  4'b0011, 4'b0010, 4'b0010, 4'b0011, 4'b0010};
        logic [13:0] exp;
        mif.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'b11, op1[i], f1[i], op0[i], f0[i]);
            step();
            exp = mk(1'b1, 1'b1, 2'b11, 2'b00, c1[i], c0[i]);
            total++;
            if (head() !== exp) begin
                bad++;
                $display("FAIL decode[%0d] got=%h exp=%h", i, head(), exp);
            end
        end
        drive(1'b0, 2'b00, 4'h0, 6'h0, 4'h0, 6'h0);
        step();
        total++;
        if ({mif.in_ready, mif.out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL decode_drain got=%b exp=10", {mif.in_ready, mif.out_valid});
        end
    endtask

    task automatic test_illegal();
        logic [3:0]  iop1 [4] = '{4'b0000, 4'b0000, 4'b1010, 4'b0000};
        logic [5:0]  if1  [4] = '{6'b000000, 6'b000000, 6'b0, 6'b101000};
        logic [3:0]  iop0 [4] = '{4'b1100, 4'b1100, 4'b1011, 4'b0001};
        logic [1:0]  ien  [4] = '{2'b11, 2'b01, 2'b11, 2'b10};
        logic [13:0] iexp [4];
        int          inc  [4] = '{2, 1, 1, 1};
        iexp[0] = mk(1'b1, 1'b1, 2'b11, 2'b11, 4'b0000, 4'b0000);
        iexp[1] = mk(1'b1, 1'b1, 2'b01, 2'b01, 4'b0000, 4'b0000);
        iexp[2] = mk(1'b1, 1'b1, 2'b11, 2'b01, 4'b1000, 4'b0000);
        iexp[3] = mk(1'b1, 1'b1, 2'b10, 2'b10, 4'b0000, 4'b0010);
        mif.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ien[i], iop1[i], if1[i], iop0[i], 6'b0);
            step();
            exp_cnt += inc[i];
            total++;
            if (head() !== iexp[i]) begin
                bad++;
                $display("FAIL illegal[%0d] got=%h exp=%h", i, head(), iexp[i]);
            end
            total++;
            if (mif.illegal_cnt_o !== 8'(exp_cnt)) begin
                bad++;
                $display("FAIL illegal_cnt[%0d] got=%0d exp=%0d", i, mif.illegal_cnt_o, exp_cnt);
            end
        end
        drive(1'b0, 2'b00, 4'h0, 6'h0, 4'h0, 6'h0);
        step();
    endtask

    task automatic test_backpressure();
        logic [13:0] exp [6];
        exp[0] = mk(1'b1, 1'b1, 2'b11, 2'b00, 4'b0001, 4'b0010);  // A head, skid empty
        exp[1] = mk(1'b0, 1'b1, 2'b11, 2'b00, 4'b0001, 4'b0010);  // B in skid
        exp[2] = mk(1'b0, 1'b1, 2'b11, 2'b00, 4'b0001, 4'b0010);  // C held, A stable
        exp[3] = mk(1'b0, 1'b1, 2'b11, 2'b00, 4'b0001, 4'b0010);
        exp[4] = mk(1'b1, 1'b1, 2'b11, 2'b00, 4'b0111, 4'b0100);  // A consumed, B head
        exp[5] = mk(1'b1, 1'b1, 2'b11, 2'b00, 4'b1000, 4'b0011);  // C accepted, B consumed
        mif.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: drive(1'b1, 2'b11, 4'b0100, 6'b0, 4'b0001, 6'b0);
                1: drive(1'b1, 2'b11, 4'b0110, 6'b0, 4'b0101, 6'b0);
                2: drive(1'b1, 2'b11, 4'b1010, 6'b0, 4'b0010, 6'b0);
                4: mif.out_ready = 1'b1;
                default: ;
            endcase
            step();
            total++;
            if (head() !== exp[i]) begin
                bad++;
                $display("FAIL backpressure[%0d] got=%h exp=%h", i, head(), exp[i]);
            end
        end
        drive(1'b0, 2'b00, 4'h0, 6'h0, 4'h0, 6'h0);
        step();
        total++;
        if ({mif.in_ready, mif.out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL backpressure_drain got=%b exp=10", {mif.in_ready, mif.out_valid});
        end
    endtask

    task automatic test_flush();
        logic [13:0] exp_full;
        exp_full = mk(1'b0, 1'b1, 2'b11, 2'b00, 4'b0001, 4'b0010);
        mif.out_ready = 1'b0;
        drive(1'b1, 2'b11, 4'b0100, 6'b0, 4'b0001, 6'b0);
        step();
        drive(1'b1, 2'b11, 4'b0110, 6'b0, 4'b0101, 6'b0);
        step();
        total++;
        if (head() !== exp_full) begin
            bad++;
            $display("FAIL flush_fill got=%h exp=%h", head(), exp_full);
        end
        // Flush with a full buffer and an illegal bundle presented.
        drive(1'b1, 2'b11, 4'b1111, 6'b0, 4'b1111, 6'b0);
        mif.flush = 1'b1;
        step();
        mif.flush = 1'b0;
        total++;
        if ({mif.in_ready, mif.out_valid} !== 2'b10 || mif.illegal_cnt_o !== 8'(exp_cnt)) begin
            bad++;
            $display("FAIL flush_full got=%b cnt=%0d exp=10 cnt=%0d",
                     {mif.in_ready, mif.out_valid}, mif.illegal_cnt_o, exp_cnt);
        end
        // Flush at count 1 while ready, with a concurrent consume.
        drive(1'b1, 2'b11, 4'b0100, 6'b0, 4'b0001, 6'b0);
        step();
        drive(1'b1, 2'b11, 4'b1111, 6'b0, 4'b1111, 6'b0);
        mif.flush     = 1'b1;
        mif.out_ready = 1'b1;
        step();
        mif.flush = 1'b0;
        drive(1'b0, 2'b00, 4'h0, 6'h0, 4'h0, 6'h0);
        total++;
        if ({mif.in_ready, mif.out_valid} !== 2'b10 || mif.illegal_cnt_o !== 8'(exp_cnt)) begin
            bad++;
            $display("FAIL flush_one got=%b cnt=%0d exp=10 cnt=%0d",
                     {mif.in_ready, mif.out_valid}, mif.illegal_cnt_o, exp_cnt);
        end
        step();
        total++;
        if (mif.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_dropped got=%b exp=0", mif.out_valid);
        end
    endtask

    task automatic test_saturation();
        mif.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'b11, 4'b1111, 6'b0, 4'b1111, 6'b0);
            step();
            exp_cnt += 2;
            total++;
            if (mif.illegal_cnt_o !== 8'(exp_cnt) || sif.illegal_cnt_o !== sat15(exp_cnt)) begin
                bad++;
                $display("FAIL saturation[%0d] got=%0d/%0d exp=%0d/%0d", i,
                         mif.illegal_cnt_o, sif.illegal_cnt_o, exp_cnt, sat15(exp_cnt));
            end
        end
        drive(1'b0, 2'b00, 4'h0, 6'h0, 4'h0, 6'h0);
        step();
        total++;
        if (sif.illegal_cnt_o !== 4'd15) begin
            bad++;
            $display("FAIL saturation_hold got=%0d exp=15", sif.illegal_cnt_o);
        end
    endtask

    task automatic test_async_reset();
        logic [13:0] exp;
        mif.out_ready = 1'b0;
        drive(1'b1, 2'b11, 4'b0100, 6'b0, 4'b0001, 6'b0);
        step();
        drive(1'b0, 2'b00, 4'h0, 6'h0, 4'h0, 6'h0);
        exp = mk(1'b1, 1'b1, 2'b11, 2'b00, 4'b0001, 4'b0010);
        total++;
        if (head() !== exp) begin
            bad++;
            $display("FAIL areset_pre got=%h exp=%h", head(), exp);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (head() !== 14'h2000 || mif.illegal_cnt_o !== 8'd0 || sif.illegal_cnt_o !== 4'd0) begin
            bad++;
            $display("FAIL areset_mid got=%h cnt=%0d/%0d exp=2000 cnt=0/0",
                     head(), mif.illegal_cnt_o, sif.illegal_cnt_o);
        end
        #1;
        rst = 1'b0;
        exp_cnt = 0;
        mif.out_ready = 1'b1;
        drive(1'b1, 2'b11, 4'b0000, 6'b100100, 4'b0000, 6'b100010);
        step();
        exp = mk(1'b1, 1'b1, 2'b11, 2'b00, 4'b0000, 4'b0110);
        total++;
        if (head() !== exp) begin
            bad++;
            $display("FAIL areset_post got=%h exp=%h", head(), exp);
        end
        drive(1'b0, 2'b00, 4'h0, 6'h0, 4'h0, 6'h0);
        step();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_illegal();
        test_backpressure();
        test_flush();
        test_saturation();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
